// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared SoC definitions. Holds the arbiter state encoding,
//                the SoC address map and a range-check helper for the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter transaction states; encoding is visible to debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // SoC address map
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] IO_BASE     = 32'h8000_0000;
  localparam logic [31:0] IO_UART_TX  = 32'h8000_0000;
  localparam logic [31:0] IO_UART_ST  = 32'h8000_0004;
  localparam logic [31:0] IO_LEDS     = 32'h8000_0008;

  localparam int unsigned WORD_BYTES  = 4;

  // True when a byte address lies at or beyond the end of the RAM.
  function automatic logic addr_out_of_range(input logic [63:0] addr,
                                             input logic [63:0] mem_words);
    return addr >= (mem_words * 64'(WORD_BYTES));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bus bundle between two requesters, the arbiter and the RAM.
//                Upper-case signals are driven by the requesters / RAM,
//                lower-case signals by the arbiter.
//  Ports       : Mx_VALID/ADDR/WDATA/WMASK  request from requester x
//                mx_ready/rvalid/rdata      accept pulse, completion, data
//                ram_addr/wdata/wmask       RAM command
//                RAM_RDATA                  RAM read data (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  M0_VALID;
  logic [ADDR_WIDTH-1:0] M0_ADDR;
  logic [31:0]           M0_WDATA;
  logic [3:0]            M0_WMASK;
  logic                  m0_ready;
  logic                  m0_rvalid;
  logic [31:0]           m0_rdata;

  logic                  M1_VALID;
  logic [ADDR_WIDTH-1:0] M1_ADDR;
  logic [31:0]           M1_WDATA;
  logic [3:0]            M1_WMASK;
  logic                  m1_ready;
  logic                  m1_rvalid;
  logic [31:0]           m1_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [3:0]            ram_wmask;
  logic [31:0]           RAM_RDATA;

  // Arbiter side
  modport slave (
    input  M0_VALID, M0_ADDR, M0_WDATA, M0_WMASK,
    input  M1_VALID, M1_ADDR, M1_WDATA, M1_WMASK,
    input  RAM_RDATA,
    output m0_ready, m0_rvalid, m0_rdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output ram_addr, ram_wdata, ram_wmask
  );

  // Requester / RAM side
  modport master (
    output M0_VALID, M0_ADDR, M0_WDATA, M0_WMASK,
    output M1_VALID, M1_ADDR, M1_WDATA, M1_WMASK,
    output RAM_RDATA,
    input  m0_ready, m0_rvalid, m0_rdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  ram_addr, ram_wdata, ram_wmask
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant. A lone request always wins;
//                on contention the requester not granted last wins.
//  Ports       : i_req[1:0]    request vector
//                i_last_grant  index of the most recently granted requester
//                o_grant[1:0]  one-hot grant (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  wire logic [1:0] i_req,
  input  wire logic       i_last_grant,
  output logic      [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port RAM between a CPU (requester 0) and
//                a loader/DMA (requester 1). Each transaction runs
//                IDLE -> ISSUE -> RESP; ready is seen in ISSUE and rvalid two
//                cycles later, giving one transaction every three cycles.
//  Ports       : CLK, RESET  clock, asynchronous active-high reset
//                bus         mem_arbiter_if.slave (requesters + RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 2048
) (
  input wire logic   CLK,
  input wire logic   RESET,
  mem_arbiter_if.slave bus
);

  state_t                state_q,  state_d;
  logic                  last_q,   last_d;    // 1: requester 1 granted last
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [31:0]           wdata_q,  wdata_d;
  logic [3:0]            wmask_q,  wmask_d;
  logic                  oor_q,    oor_d;
  logic [1:0]            ready_q,  ready_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [31:0]           rdata_q,  rdata_d;

  logic [1:0]            w_grant;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [3:0]            w_sel_wmask;
  logic                  w_sel_oor;

  rr_arbiter2 u_rr (
    .i_req        ({bus.M1_VALID, bus.M0_VALID}),
    .i_last_grant (last_q),
    .o_grant      (w_grant)
  );

  assign w_sel_addr  = w_grant[1] ? bus.M1_ADDR  : bus.M0_ADDR;
  assign w_sel_wdata = w_grant[1] ? bus.M1_WDATA : bus.M0_WDATA;
  assign w_sel_wmask = w_grant[1] ? bus.M1_WMASK : bus.M0_WMASK;
  assign w_sel_oor   = addr_out_of_range(64'(w_sel_addr), 64'(MEM_WORDS));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    oor_d    = oor_q;
    ready_d  = 2'b00;
    rvalid_d = 2'b00;
    rdata_d  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        // Requests are only looked at here; a VALID raised during
        // ISSUE/RESP simply waits until the FSM comes back to IDLE.
        if (|w_grant) begin
          state_d = ST_ISSUE;
          ready_d = w_grant;
          last_d  = w_grant[1];
          addr_d  = w_sel_addr;
          wdata_d = w_sel_wdata;
          wmask_d = w_sel_wmask;
          oor_d   = w_sel_oor;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        // RAM_RDATA answers the address driven during ISSUE.
        state_d  = ST_IDLE;
        rvalid_d = last_q ? 2'b10 : 2'b01;
        rdata_d  = oor_q ? 32'h0 : bus.RAM_RDATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      wmask_q  <= 4'h0;
      oor_q    <= 1'b0;
      ready_q  <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      oor_q    <= oor_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.m0_ready  = ready_q[0];
  assign bus.m1_ready  = ready_q[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rvalid_q[0] ? rdata_q : 32'h0;
  assign bus.m1_rdata  = rvalid_q[1] ? rdata_q : 32'h0;

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  // Decoded from the state register so an asynchronous reset clears the
  // write enable in the same cycle it is asserted.
  assign bus.ram_wmask = (state_q == ST_ISSUE && !oor_q) ? wmask_q : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                byte-masked RAM model whose index ignores high address bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   both_cnt;
  int   rv_cnt;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .MEM_WORDS(2048)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 2048 words, one-cycle read latency, index aliases high bits.
  logic [31:0] mem [0:2047];
  logic [10:0] ram_idx;
  assign ram_idx = bus.ram_addr[12:2];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.ram_wmask[b]) mem[ram_idx][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end
    bus.RAM_RDATA <= mem[ram_idx];
  end

  always @(negedge clk) begin
    if ((bus.m0_ready && bus.m1_ready) || (bus.m0_rvalid && bus.m1_rvalid))
      both_cnt++;
    if (bus.m0_rvalid || bus.m1_rvalid) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] wm);
    if (m == 0) begin
      bus.M0_VALID = v; bus.M0_ADDR = a; bus.M0_WDATA = d; bus.M0_WMASK = wm;
    end else begin
      bus.M1_VALID = v; bus.M1_ADDR = a; bus.M1_WDATA = d; bus.M1_WMASK = wm;
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 1) ? bus.m1_ready : bus.m0_ready;
  endfunction

  function automatic logic rv(input int m);
    return (m == 1) ? bus.m1_rvalid : bus.m0_rvalid;
  endfunction

  function automatic logic [31:0] rd(input int m);
    return (m == 1) ? bus.m1_rdata : bus.m0_rdata;
  endfunction

  // One transaction from requester m. Returns completion data, the
  // ready->rvalid latency, the RAM mask during ISSUE and RESP, and the
  // requester's rdata during RESP (rvalid still low).
  task automatic do_req(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] wm, output logic [31:0] rdata,
                        output int lat, output logic [3:0] wm_issue,
                        output logic [3:0] wm_resp, output logic [31:0] rd_resp);
    int n;
    n = 0; lat = 0; rdata = 32'h0; wm_issue = 4'h0; wm_resp = 4'h0; rd_resp = 32'h0;
    set_req(m, 1'b1, a, d, wm);
    do begin tick(); n++; end while (!rdy(m) && n < 10);
    set_req(m, 1'b0, 32'h0, 32'h0, 4'h0);
    if (!rdy(m)) begin
      check("ready_timeout", 32'(n), 32'd1);
      return;
    end
    wm_issue = bus.ram_wmask;
    do begin
      tick(); lat++;
      if (lat == 1) begin wm_resp = bus.ram_wmask; rd_resp = rd(m); end
    end while (!rv(m) && lat < 10);
    rdata = rd(m);
  endtask

  logic [31:0] r, rr;
  int          lat;
  logic [3:0]  wmi, wmr;
  int          seq [0:7];
  int          k;
  int          rv_base;

  initial begin
    n_total = 0; n_bad = 0; both_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
    mem[0] <= 32'hA5A5_A5A5;
    mem[1] <= 32'h1111_0001;
    mem[2] <= 32'h2222_0002;
    mem[3] <= 32'h0040_0237;
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick();

    // Reset state
    check("rst_m0_ready",  32'(bus.m0_ready),  32'd0);
    check("rst_m1_ready",  32'(bus.m1_ready),  32'd0);
    check("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check("rst_ram_wmask", 32'(bus.ram_wmask), 32'd0);
    check("rst_ram_addr",  bus.ram_addr,       32'd0);
    check("rst_ram_wdata", bus.ram_wdata,      32'd0);
    rst = 1'b0;
    tick();

    // Read of word 3
    do_req(0, 32'hC, 32'h0, 4'h0, r, lat, wmi, wmr, rr);
    check("rd_latency",    32'(lat), 32'd2);
    check("rd_data",       r,        32'h0040_0237);
    check("rd_rdata_low",  rr,       32'h0);
    check("rd_wmask",      32'(wmi), 32'd0);

    // Contention right after reset: M0 first, M1 three cycles later
    rst = 1'b1; tick(); rst = 1'b0; tick();
    set_req(0, 1'b1, 32'h4, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    check("cont_m0_ready", 32'(bus.m0_ready), 32'd1);
    check("cont_m1_ready", 32'(bus.m1_ready), 32'd0);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick();
    check("cont_m0_rdata", bus.m0_rdata, 32'h1111_0001);
    tick();
    check("cont_m1_ready", 32'(bus.m1_ready), 32'd1);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick();
    check("cont_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check("cont_m1_rdata",  bus.m1_rdata,       32'hA5A5_A5A5);

    // Fairness: both held valid for 12 cycles
    set_req(0, 1'b1, 32'h4, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h8, 32'h0, 4'h0);
    k = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.m0_ready && k < 8) begin seq[k] = 0; k++; end
      if (bus.m1_ready && k < 8) begin seq[k] = 1; k++; end
    end
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    check("fair_count", 32'(k), 32'd4);
    if (k == 4) begin
      check("fair_g0", 32'(seq[0]), 32'd0);
      check("fair_g1", 32'(seq[1]), 32'd1);
      check("fair_g2", 32'(seq[2]), 32'd0);
      check("fair_g3", 32'(seq[3]), 32'd1);
    end
    tick(); tick(); tick();

    // Write by M1, then read back by M0
    do_req(1, 32'h20, 32'hDEAD_BEEF, 4'hF, r, lat, wmi, wmr, rr);
    check("wr_latency",     32'(lat), 32'd2);
    check("wr_wmask_issue", 32'(wmi), 32'hF);
    check("wr_wmask_resp",  32'(wmr), 32'h0);
    check("wr_wmask_after", 32'(bus.ram_wmask), 32'h0);
    do_req(0, 32'h20, 32'h0, 4'h0, r, lat, wmi, wmr, rr);
    check("wr_readback",    r, 32'hDEAD_BEEF);

    // Partial byte write, read back by M1
    do_req(0, 32'h20, 32'h1122_3344, 4'b0101, r, lat, wmi, wmr, rr);
    check("pw_wmask_issue", 32'(wmi), 32'h5);
    do_req(1, 32'h20, 32'h0, 4'h0, r, lat, wmi, wmr, rr);
    check("pw_readback",    r, 32'hDE22_BE44);

    // Out of range: first address past the RAM
    do_req(0, 32'd8192, 32'hFFFF_FFFF, 4'hF, r, lat, wmi, wmr, rr);
    check("oor_wr_wmask",   32'(wmi), 32'h0);
    check("oor_wr_latency", 32'(lat), 32'd2);
    check("oor_wr_rdata",   r,        32'h0);
    do_req(0, 32'd8192, 32'h0, 4'h0, r, lat, wmi, wmr, rr);
    check("oor_rd_rdata",   r,        32'h0);
    check("oor_no_alias_wr", mem[0],  32'hA5A5_A5A5);

    // Reset during ISSUE of an M0 write
    set_req(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
    tick();
    check("rst_issue_ready", 32'(bus.m0_ready),  32'd1);
    check("rst_issue_wmask", 32'(bus.ram_wmask), 32'hF);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    rv_base = rv_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_async_wmask", 32'(bus.ram_wmask), 32'h0);
    check("rst_async_ready", 32'(bus.m0_ready),  32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("rst_no_rvalid", 32'(rv_cnt - rv_base), 32'd0);
    check("rst_no_write",  mem[16], 32'h0);
    set_req(0, 1'b1, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h4, 32'h0, 4'h0);
    tick();
    check("rst_next_m0", 32'(bus.m0_ready), 32'd1);
    check("rst_next_m1", 32'(bus.m1_ready), 32'd0);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick(); tick();

    check("never_both", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
